// File: rtl/io_ctrl_pkg.sv
// Shared constants and FSM encoding for the GPIO port access controller.
package io_ctrl_pkg;

  localparam int unsigned WIDTH_DEF = 8;

  localparam logic SEL_DATA = 1'b0;
  localparam logic SEL_TRIS = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

endpackage

// File: rtl/io_rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last winner and
// moves only when a grant is actually taken.
module io_rr_arb2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic r_last;

  always_comb begin
    grant = '0;
    if (req == 2'b11) grant = r_last ? 2'b01 : 2'b10;
    else              grant = req;
  end

  // Reset to requester 1 so requester 0 wins the first tie.
  always_ff @(posedge clock) begin
    if (reset)                  r_last <= 1'b1;
    else if (advance && |grant) r_last <= grant[1];
  end

endmodule

// File: rtl/io_port_ctrl.sv
// Arbitrated two-requester access controller in front of a GPIO register
// block: data writes/reads go to the pins, TRIS accesses stay local.
module io_port_ctrl
  import io_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             r0_req,
  input  logic             r0_we,
  input  logic             r0_sel,
  input  logic [WIDTH-1:0] r0_wdata,
  output logic             r0_ack,
  output logic [WIDTH-1:0] r0_rdata,
  input  logic             r1_req,
  input  logic             r1_we,
  input  logic             r1_sel,
  input  logic [WIDTH-1:0] r1_wdata,
  output logic             r1_ack,
  output logic [WIDTH-1:0] r1_rdata,
  output logic             io_write_en,
  output logic             io_out_en,
  output logic [WIDTH-1:0] io_data_in,
  output logic [WIDTH-1:0] io_inout_sel,
  input  logic [WIDTH-1:0] io_data_out
);

  state_t           r_state, w_next;
  logic             r_we, r_sel, r_gnt_id;
  logic [WIDTH-1:0] r_wdata, r_tris, r_rdata;
  logic [1:0]       w_grant;
  logic             w_advance, w_gnt_we, w_gnt_sel;
  logic [WIDTH-1:0] w_gnt_wdata;

  assign w_advance   = (r_state == ST_IDLE) && (r0_req || r1_req);
  assign w_gnt_we    = w_grant[0] ? r0_we    : r1_we;
  assign w_gnt_sel   = w_grant[0] ? r0_sel   : r1_sel;
  assign w_gnt_wdata = w_grant[0] ? r0_wdata : r1_wdata;
  assign io_inout_sel = r_tris;

  io_rr_arb2 u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     ({r1_req, r0_req}),
    .advance (w_advance),
    .grant   (w_grant)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_we     <= 1'b0;
      r_sel    <= SEL_DATA;
      r_gnt_id <= 1'b0;
      r_wdata  <= '0;
      r_tris   <= '0;
      r_rdata  <= '0;
    end else begin
      r_state <= w_next;
      if (w_advance) begin
        r_gnt_id <= w_grant[1];
        r_we     <= w_gnt_we;
        r_sel    <= w_gnt_sel;
        r_wdata  <= w_gnt_wdata;
        r_rdata  <= '0;
      end
      if (r_state == ST_WRITE && r_sel == SEL_TRIS) r_tris <= r_wdata;
      if (r_state == ST_READ)
        r_rdata <= (r_sel == SEL_TRIS) ? r_tris : io_data_out;
    end
  end

  always_comb begin
    w_next      = r_state;
    r0_ack      = 1'b0;
    r1_ack      = 1'b0;
    r0_rdata    = '0;
    r1_rdata    = '0;
    io_write_en = 1'b0;
    io_out_en   = 1'b0;
    io_data_in  = '0;

    unique case (r_state)
      ST_IDLE:  if (w_advance) w_next = w_gnt_we ? ST_WRITE : ST_READ;
      ST_WRITE: w_next = ST_ACK;
      ST_READ:  w_next = ST_ACK;
      ST_ACK:   w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase

    // Strobes and acks are masked during reset so an in-flight access is
    // dropped in the very cycle reset is sampled.
    if (!reset) begin
      unique case (r_state)
        ST_WRITE: begin
          io_write_en = (r_sel == SEL_DATA);
          io_data_in  = r_wdata;
        end
        ST_READ:  io_out_en = (r_sel == SEL_DATA);
        ST_ACK: begin
          if (r_gnt_id) begin
            r1_ack   = 1'b1;
            r1_rdata = r_rdata;
          end else begin
            r0_ack   = 1'b1;
            r0_rdata = r_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_io_port_ctrl.sv
// Scoreboard bench for io_port_ctrl: stimulus predicts acks/strobes into
// queues, a negedge monitor pops and compares them.
module tb_io_port_ctrl;
  import io_ctrl_pkg::*;

  localparam int unsigned W = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         r0_req = 1'b0, r0_we = 1'b0, r0_sel = 1'b0;
  logic [W-1:0] r0_wdata = '0;
  logic         r1_req = 1'b0, r1_we = 1'b0, r1_sel = 1'b0;
  logic [W-1:0] r1_wdata = '0;
  logic         r0_ack, r1_ack, io_write_en, io_out_en;
  logic [W-1:0] r0_rdata, r1_rdata, io_data_in, io_inout_sel;
  logic [W-1:0] io_data_out = '0;

  io_port_ctrl #(.WIDTH(W)) dut (
    .clock        (clock),
    .reset        (reset),
    .r0_req       (r0_req),
    .r0_we        (r0_we),
    .r0_sel       (r0_sel),
    .r0_wdata     (r0_wdata),
    .r0_ack       (r0_ack),
    .r0_rdata     (r0_rdata),
    .r1_req       (r1_req),
    .r1_we        (r1_we),
    .r1_sel       (r1_sel),
    .r1_wdata     (r1_wdata),
    .r1_ack       (r1_ack),
    .r1_rdata     (r1_rdata),
    .io_write_en  (io_write_en),
    .io_out_en    (io_out_en),
    .io_data_in   (io_data_in),
    .io_inout_sel (io_inout_sel),
    .io_data_out  (io_data_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    int           id;
    logic [W-1:0] rdata;
    logic         tris_wr;
    logic [W-1:0] wdata;
  } exp_t;

  exp_t         ack_q[$];
  logic [W-1:0] wr_q[$];
  int           checks = 0;
  int           failures = 0;
  logic [W-1:0] m_tris = '0;
  int           m_last = 1;
  logic [W-1:0] mon_tris = '0;
  exp_t         mon_e;
  logic [W-1:0] mon_wd;

  function automatic void chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: applies an access in grant order to the abstract port.
  function automatic void predict(input int id, input logic we, input logic sel,
                                  input logic [W-1:0] wd);
    exp_t e;
    e.id = id; e.tris_wr = we && sel; e.wdata = wd; e.rdata = '0;
    if (we) begin
      if (sel) m_tris = wd;
      else     wr_q.push_back(wd);
    end else begin
      e.rdata = sel ? m_tris : io_data_out;
    end
    ack_q.push_back(e);
  endfunction

  task automatic drive(input int id, input logic rq, input logic we, input logic sel,
                       input logic [W-1:0] wd);
    if (id == 0) begin
      r0_req = rq; r0_we = we; r0_sel = sel; r0_wdata = wd;
    end else begin
      r1_req = rq; r1_we = we; r1_sel = sel; r1_wdata = wd;
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      mon_tris = '0;
      chk("reset_ctrl_outs", {r0_ack, r1_ack, io_write_en, io_out_en}, 0);
      chk("reset_data_outs", {io_data_in, r0_rdata, r1_rdata}, 0);
    end else begin
      if (r0_ack || r1_ack) begin
        chk("ack_onehot", r0_ack & r1_ack, 0);
        if (ack_q.size() == 0) begin
          chk("ack_unexpected", 1, 0);
        end else begin
          mon_e = ack_q.pop_front();
          chk("ack_id", r1_ack ? 1 : 0, mon_e.id);
          chk("ack_rdata", r1_ack ? r1_rdata : r0_rdata, mon_e.rdata);
          chk("other_rdata", r1_ack ? r0_rdata : r1_rdata, 0);
          if (mon_e.tris_wr) mon_tris = mon_e.wdata;
        end
      end
      if (io_write_en || io_out_en) chk("strobe_excl", io_write_en & io_out_en, 0);
      if (io_write_en) begin
        if (wr_q.size() == 0) begin
          chk("write_unexpected", 1, 0);
        end else begin
          mon_wd = wr_q.pop_front();
          chk("write_data", io_data_in, mon_wd);
        end
      end
      chk("inout_sel", io_inout_sel, mon_tris);
    end
  end

  // Called at posedge+1 with the controller idle; returns at posedge+1.
  task automatic single_op(input int id, input logic we, input logic sel,
                           input logic [W-1:0] wd);
    int cnt;
    bit got;
    predict(id, we, sel, wd);
    m_last = id;
    drive(id, 1'b1, we, sel, wd);
    @(posedge clock);
    cnt = 0; got = 0;
    while (!got && cnt < 10) begin
      @(negedge clock);
      cnt++;
      if (cnt == 1) begin
        chk("op_write_en", io_write_en, (we && sel == SEL_DATA) ? 1 : 0);
        chk("op_out_en", io_out_en, (!we && sel == SEL_DATA) ? 1 : 0);
      end
      if ((id == 0) ? r0_ack : r1_ack) got = 1;
    end
    chk("op_latency", got ? cnt : 99, 2);
    @(posedge clock); #1;
    drive(id, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic both_op(input logic we0, input logic sel0, input logic [W-1:0] wd0,
                         input logic we1, input logic sel1, input logic [W-1:0] wd1);
    int first, second, cnt, t0, t1;
    first  = (m_last == 1) ? 0 : 1;
    second = 1 - first;
    if (first == 0) begin
      predict(0, we0, sel0, wd0); predict(1, we1, sel1, wd1);
    end else begin
      predict(1, we1, sel1, wd1); predict(0, we0, sel0, wd0);
    end
    m_last = second;
    drive(0, 1'b1, we0, sel0, wd0);
    drive(1, 1'b1, we1, sel1, wd1);
    @(posedge clock);
    cnt = 0; t0 = 0; t1 = 0;
    while ((t0 == 0 || t1 == 0) && cnt < 20) begin
      @(negedge clock);
      cnt++;
      if (r0_ack && t0 == 0) t0 = cnt;
      if (r1_ack && t1 == 0) t1 = cnt;
      @(posedge clock); #1;
      if (t0 != 0) drive(0, 1'b0, 1'b0, 1'b0, '0);
      if (t1 != 0) drive(1, 1'b0, 1'b0, 1'b0, '0);
    end
    chk("tie_first_latency", (first == 0) ? t0 : t1, 2);
    chk("tie_second_latency", (first == 0) ? t1 : t0, 5);
    drive(0, 1'b0, 1'b0, 1'b0, '0);
    drive(1, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic reset_mid_write();
    drive(0, 1'b1, 1'b1, SEL_TRIS, 8'hFF);
    @(posedge clock); #1;
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, '0);
    @(negedge clock);
    chk("rstmid_write_en", io_write_en, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    m_tris = '0;
    m_last = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("rstmid_no_ack", {r0_ack, r1_ack}, 0);
      chk("rstmid_tris", io_inout_sel, 0);
    end
    @(posedge clock); #1;
  endtask

  initial begin
    logic         we0, we1, sel0, sel1;
    logic [W-1:0] wd0, wd1;
    int           mode;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    chk("reset_inout_sel", io_inout_sel, 0);

    single_op(0, 1'b1, SEL_TRIS, 8'h0F);
    single_op(1, 1'b1, SEL_DATA, 8'hA5);
    io_data_out = 8'h3C;
    single_op(0, 1'b0, SEL_DATA, '0);
    single_op(0, 1'b1, SEL_TRIS, 8'hF0);
    single_op(1, 1'b0, SEL_TRIS, '0);
    both_op(1'b1, SEL_DATA, 8'h11, 1'b1, SEL_DATA, 8'h22);
    both_op(1'b0, SEL_DATA, '0, 1'b0, SEL_TRIS, '0);
    reset_mid_write();
    both_op(1'b0, SEL_TRIS, '0, 1'b1, SEL_TRIS, 8'h5A);

    for (int i = 0; i < 80; i++) begin
      io_data_out = W'($urandom);
      mode = int'($urandom_range(0, 2));
      we0  = 1'($urandom_range(0, 1)); sel0 = 1'($urandom_range(0, 1));
      we1  = 1'($urandom_range(0, 1)); sel1 = 1'($urandom_range(0, 1));
      wd0  = W'($urandom);             wd1  = W'($urandom);
      case (mode)
        0:       single_op(0, we0, sel0, wd0);
        1:       single_op(1, we1, sel1, wd1);
        default: both_op(we0, sel0, wd0, we1, sel1, wd1);
      endcase
    end

    repeat (4) @(posedge clock);
    chk("ack_queue_drained", ack_q.size(), 0);
    chk("write_queue_drained", wr_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
